// File: rtl/retro_memory_pkg.sv
`default_nettype none
// ============================================================================
// retro_memory_pkg : shared types and round-robin helper for the memory arbiter
// Revision 1.0
// ============================================================================
package retro_memory_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } arb_state_t;

    localparam int unsigned c_MAX_REQ = 8;

    // First set bit of vec scanning ptr, ptr+1, ... modulo n; 0 when vec is empty.
    function automatic int unsigned rr_next(
        input logic [c_MAX_REQ-1:0] vec,
        input int unsigned          ptr,
        input int unsigned          n
    );
        int unsigned idx;
        int unsigned win;
        logic        found;
        win   = 0;
        found = 1'b0;
        for (int unsigned k = 0; k < c_MAX_REQ; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && vec[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage
`default_nettype wire

// File: rtl/retro_rr_picker.sv
`default_nettype none
// ============================================================================
// retro_rr_picker : combinational round-robin winner selection
// Revision 1.0
// ============================================================================
module retro_rr_picker #(
    parameter int Requesters = 4
) (
    input  logic [Requesters-1:0]         req_i,
    input  logic [$clog2(Requesters)-1:0] ptr_i,
    output logic [$clog2(Requesters)-1:0] winner_o,
    output logic                          any_o
);
    import retro_memory_pkg::*;

    localparam int c_GW = $clog2(Requesters);

    logic [c_MAX_REQ-1:0] w_vec;

    always_comb begin
        w_vec                 = '0;
        w_vec[Requesters-1:0] = req_i;
    end

    assign winner_o = c_GW'(rr_next(w_vec, 32'(ptr_i), Requesters));
    assign any_o    = |req_i;

endmodule
`default_nettype wire

// File: rtl/retro_memory_arbiter.sv
`default_nettype none
// ============================================================================
// retro_memory_arbiter : round-robin sharing of one HyperRAM controller port
// Revision 1.0
// ============================================================================
module retro_memory_arbiter #(
    parameter int Requesters      = 4,
    parameter int AddressBusWidth = 16,
    parameter int DataBusWidth    = 8
) (
    input  logic                                  Clk_i,
    input  logic                                  Reset_i,
    input  logic [Requesters-1:0]                 ReqValid_i,
    input  logic [Requesters-1:0]                 ReqWrite_i,
    input  logic [Requesters*AddressBusWidth-1:0] ReqAddress_i,
    input  logic [Requesters*DataBusWidth-1:0]    ReqData_i,
    output logic [Requesters-1:0]                 ReqAck_o,
    output logic [DataBusWidth-1:0]               ReqRData_o,
    output logic                                  MemValid_o,
    output logic                                  MemWrite_o,
    output logic [AddressBusWidth-1:0]            MemAddress_o,
    output logic [DataBusWidth-1:0]               MemWData_o,
    input  logic                                  MemReady_i,
    input  logic [DataBusWidth-1:0]               MemRData_i,
    output logic [$clog2(Requesters)-1:0]         Grant_o
);
    import retro_memory_pkg::*;

    localparam int c_GW = $clog2(Requesters);

    arb_state_t                 state_q, state_d;
    logic [c_GW-1:0]            ptr_q, ptr_d;
    logic [c_GW-1:0]            grant_q, grant_d;
    logic                       mem_valid_q, mem_valid_d;
    logic                       mem_write_q, mem_write_d;
    logic [AddressBusWidth-1:0] mem_addr_q, mem_addr_d;
    logic [DataBusWidth-1:0]    mem_wdata_q, mem_wdata_d;
    logic [Requesters-1:0]      ack_q, ack_d;
    logic [DataBusWidth-1:0]    rdata_q, rdata_d;

    logic [c_GW-1:0]            w_win;
    logic                       w_any;
    logic [AddressBusWidth-1:0] w_sel_addr;
    logic [DataBusWidth-1:0]    w_sel_data;

    retro_rr_picker #(
        .Requesters (Requesters)
    ) u_picker (
        .req_i    (ReqValid_i),
        .ptr_i    (ptr_q),
        .winner_o (w_win),
        .any_o    (w_any)
    );

    always_comb begin
        w_sel_addr = '0;
        w_sel_data = '0;
        for (int i = 0; i < Requesters; i++) begin
            if (w_win == c_GW'(i)) begin
                w_sel_addr = ReqAddress_i[i*AddressBusWidth +: AddressBusWidth];
                w_sel_data = ReqData_i[i*DataBusWidth +: DataBusWidth];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        grant_d     = grant_q;
        mem_valid_d = mem_valid_q;
        mem_write_d = mem_write_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        ack_d       = '0;
        case (state_q)
            IDLE: begin
                if (w_any) begin
                    grant_d     = w_win;
                    mem_valid_d = 1'b1;
                    mem_write_d = ReqWrite_i[w_win];
                    mem_addr_d  = w_sel_addr;
                    mem_wdata_d = w_sel_data;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                // ReqValid is deliberately ignored here so a withdrawn request still completes.
                if (MemReady_i) begin
                    mem_valid_d    = 1'b0;
                    ack_d[grant_q] = 1'b1;
                    rdata_d        = MemRData_i;
                    ptr_d          = (grant_q == c_GW'(Requesters - 1)) ? '0 : grant_q + 1'b1;
                    state_d        = ACK;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            grant_q     <= '0;
            mem_valid_q <= 1'b0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ack_q       <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            grant_q     <= grant_d;
            mem_valid_q <= mem_valid_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            ack_q       <= ack_d;
            rdata_q     <= rdata_d;
        end
    end

    assign ReqAck_o     = ack_q;
    assign ReqRData_o   = rdata_q;
    assign MemValid_o   = mem_valid_q;
    assign MemWrite_o   = mem_write_q;
    assign MemAddress_o = mem_addr_q;
    assign MemWData_o   = mem_wdata_q;
    assign Grant_o      = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_retro_memory_arbiter.sv
`default_nettype none
// ============================================================================
// tb_retro_memory_arbiter : scoreboard bench for the round-robin memory arbiter
// Revision 1.0
// ============================================================================
module tb_retro_memory_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } mem_exp_t;

    typedef struct packed {
        logic [3:0] ack;
        logic [7:0] rdata;
    } ack_exp_t;

    logic        clk;
    logic        Reset;
    logic [3:0]  ReqValid;
    logic [3:0]  ReqWrite;
    logic [63:0] ReqAddress;
    logic [31:0] ReqData;
    logic [3:0]  ReqAck;
    logic [7:0]  ReqRData;
    logic        MemValid;
    logic        MemWrite;
    logic [15:0] MemAddress;
    logic [7:0]  MemWData;
    logic        MemReady;
    logic [7:0]  MemRData;
    logic [1:0]  Grant;

    int          n_cmp;
    int          n_fail;
    mem_exp_t    exp_mem[$];
    ack_exp_t    exp_ack[$];
    int          remaining[4];
    logic        withdraw[4];
    logic [15:0] addr_v[4];
    logic [7:0]  data_v[4];
    logic        write_v[4];
    int          mem_lat;

    retro_memory_arbiter #(
        .Requesters      (4),
        .AddressBusWidth (16),
        .DataBusWidth    (8)
    ) dut (
        .Clk_i        (clk),
        .Reset_i      (Reset),
        .ReqValid_i   (ReqValid),
        .ReqWrite_i   (ReqWrite),
        .ReqAddress_i (ReqAddress),
        .ReqData_i    (ReqData),
        .ReqAck_o     (ReqAck),
        .ReqRData_o   (ReqRData),
        .MemValid_o   (MemValid),
        .MemWrite_o   (MemWrite),
        .MemAddress_o (MemAddress),
        .MemWData_o   (MemWData),
        .MemReady_i   (MemReady),
        .MemRData_i   (MemRData),
        .Grant_o      (Grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] mdl(input logic [15:0] a);
        return a[15:8] ^ a[7:0] ^ 8'h83;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Controller model: answers each request after mem_lat cycles with data derived from the address.
    initial begin
        int cnt;
        cnt      = 0;
        MemReady = 1'b0;
        MemRData = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            MemReady = 1'b0;
            if (!Reset && MemValid) begin
                if (cnt >= mem_lat - 1) begin
                    MemReady = 1'b1;
                    MemRData = mdl(MemAddress);
                    cnt      = 0;
                end else begin
                    cnt++;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: checks each presented request and each completion against the scoreboard.
    initial begin
        logic     prev_valid;
        logic     prev_ready;
        mem_exp_t cap;
        mem_exp_t me;
        ack_exp_t ae;
        prev_valid = 1'b0;
        prev_ready = 1'b0;
        cap        = '0;
        forever begin
            @(negedge clk);
            if (!Reset) begin
                if (MemValid && !prev_valid) begin
                    if (exp_mem.size() == 0) begin
                        check("unexpected_request", 64'(MemValid), 64'd0);
                    end else begin
                        me = exp_mem.pop_front();
                        check("grant", 64'(Grant), 64'(me.grant));
                        check("mem_write", 64'(MemWrite), 64'(me.wr));
                        check("mem_address", 64'(MemAddress), 64'(me.addr));
                        check("mem_wdata", 64'(MemWData), 64'(me.wdata));
                    end
                    cap = '{grant: Grant, wr: MemWrite, addr: MemAddress, wdata: MemWData};
                end
                if (MemValid && MemReady) begin
                    check("mem_fields_held", 64'({Grant, MemWrite, MemAddress, MemWData}), 64'(cap));
                end
                if (ReqAck != 4'b0000) begin
                    if (exp_ack.size() == 0) begin
                        check("unexpected_ack", 64'(ReqAck), 64'd0);
                    end else begin
                        ae = exp_ack.pop_front();
                        check("req_ack", 64'(ReqAck), 64'(ae.ack));
                        check("req_rdata", 64'(ReqRData), 64'(ae.rdata));
                        check("ready_to_ack_latency", 64'(prev_ready), 64'd1);
                    end
                end
            end
            prev_valid = MemValid;
            prev_ready = MemReady;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (ReqAck[i] && remaining[i] > 0) begin
                remaining[i]--;
            end
            ReqValid[i]            = (remaining[i] > 0) && !(withdraw[i] && MemValid && (Grant == 2'(i)));
            ReqWrite[i]            = write_v[i];
            ReqAddress[i*16 +: 16] = addr_v[i];
            ReqData[i*8 +: 8]      = data_v[i];
        end
    endtask

    task automatic expect_txn(input int i, input logic [7:0] rd, input logic completes);
        exp_mem.push_back('{grant: 2'(i), wr: write_v[i], addr: addr_v[i], wdata: data_v[i]});
        if (completes) begin
            exp_ack.push_back('{ack: 4'(1 << i), rdata: rd});
        end
    endtask

    function automatic logic busy();
        logic b;
        b = MemValid || (exp_ack.size() != 0);
        for (int i = 0; i < 4; i++) begin
            if (remaining[i] > 0) begin
                b = 1'b1;
            end
        end
        return b;
    endfunction

    task automatic drain(input string name, input int budget);
        int n;
        n = 0;
        while (busy() && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(busy()), 64'd0);
        step();
        step();
    endtask

    task automatic wait_memvalid(input string name, input int budget);
        int n;
        n = 0;
        while (!MemValid && n < budget) begin
            step();
            n++;
        end
        check(name, 64'(MemValid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp      = 0;
        n_fail     = 0;
        Reset      = 1'b1;
        ReqValid   = '0;
        ReqWrite   = '0;
        ReqAddress = '0;
        ReqData    = '0;
        mem_lat    = 2;
        for (int i = 0; i < 4; i++) begin
            remaining[i] = 1;
            withdraw[i]  = 1'b0;
            addr_v[i]    = 16'h1000 * 16'(i) + 16'h0021;
            data_v[i]    = 8'h40 + 8'(i);
            write_v[i]   = i[0];
        end

        // Reset held two cycles with all initiators requesting; grants start at 0.
        for (int i = 0; i < 4; i++) begin
            expect_txn(i, mdl(addr_v[i]), 1'b1);
        end
        step();
        @(negedge clk);
        check("reset_outputs_c1", 64'({ReqAck, ReqRData, MemValid, MemWrite, MemAddress, MemWData, Grant}), 64'd0);
        step();
        @(negedge clk);
        check("reset_outputs_c2", 64'({ReqAck, ReqRData, MemValid, MemWrite, MemAddress, MemWData, Grant}), 64'd0);
        Reset = 1'b0;
        drain("drain_after_reset", 200);

        // Round robin with all four requesting continuously: 0,1,2,3,0,1.
        remaining[0] = 2;
        remaining[1] = 2;
        remaining[2] = 1;
        remaining[3] = 1;
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        expect_txn(1, mdl(addr_v[1]), 1'b1);
        expect_txn(2, mdl(addr_v[2]), 1'b1);
        expect_txn(3, mdl(addr_v[3]), 1'b1);
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        expect_txn(1, mdl(addr_v[1]), 1'b1);
        drain("drain_round_robin", 300);

        // Single read from initiator 2 with a 5-cycle controller.
        mem_lat    = 5;
        addr_v[2]  = 16'h1234;
        write_v[2] = 1'b0;
        data_v[2]  = 8'h77;
        expect_txn(2, 8'hA5, 1'b1);
        remaining[2] = 1;
        step();
        @(negedge clk);
        check("memvalid_before_latch", 64'(MemValid), 64'd0);
        step();
        @(negedge clk);
        check("reqvalid_to_memvalid", 64'(MemValid), 64'd1);
        drain("drain_single_read", 100);

        // Starvation: initiator 0 keeps requesting, initiator 3 joins once and goes next.
        mem_lat      = 3;
        remaining[0] = 4;
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        expect_txn(3, mdl(addr_v[3]), 1'b1);
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        expect_txn(0, mdl(addr_v[0]), 1'b1);
        wait_memvalid("starve_first_grant", 20);
        remaining[3] = 1;
        drain("drain_starvation", 300);

        // Write from initiator 1 that withdraws its request while the controller is busy.
        mem_lat      = 4;
        addr_v[1]    = 16'h00FF;
        data_v[1]    = 8'h3C;
        write_v[1]   = 1'b1;
        withdraw[1]  = 1'b1;
        expect_txn(1, 8'h7C, 1'b1);
        remaining[1] = 1;
        drain("drain_write_withdraw", 100);
        withdraw[1]  = 1'b0;

        // Reset while busy: no completion, pointer back to 0 so initiator 1 beats 3.
        mem_lat    = 50;
        addr_v[2]  = 16'hBEEF;
        write_v[2] = 1'b0;
        expect_txn(2, 8'h00, 1'b0);
        remaining[2] = 1;
        wait_memvalid("abort_request_issued", 20);
        step();
        step();
        Reset        = 1'b1;
        remaining[2] = 0;
        step();
        @(negedge clk);
        check("abort_memvalid_dropped", 64'(MemValid), 64'd0);
        check("abort_outputs_reset", 64'({ReqAck, ReqRData, MemValid, MemWrite, MemAddress, MemWData, Grant}), 64'd0);
        Reset        = 1'b0;
        mem_lat      = 2;
        remaining[1] = 1;
        remaining[3] = 1;
        expect_txn(1, mdl(addr_v[1]), 1'b1);
        expect_txn(3, mdl(addr_v[3]), 1'b1);
        drain("drain_after_abort", 200);

        check("scoreboard_mem_empty", 64'(exp_mem.size()), 64'd0);
        check("scoreboard_ack_empty", 64'(exp_ack.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
